// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants, the ID/EX stage action encoding and a
// register-match helper used by bypass, hazard and snoop logic.
package riscv_pkg;

    localparam int XLEN     = 32;
    localparam int REG_AW   = 5;
    localparam int CTRL_W   = 16;
    localparam int LOAD_BIT = 0;

    typedef enum logic [1:0] {
        ACT_FLUSH,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_CAPTURE
    } stage_act_e;

    // True when b names the same architectural register as a, ignoring x0.
    function automatic logic reg_hit(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] b);
        return (a != '0) && (a == b);
    endfunction

endpackage

// File: rtl/operand_bypass.sv
// Selects one source operand: x0 reads as zero, a same-cycle WB write to
// the source wins over the regFile read, otherwise the regFile value.
module operand_bypass
    import riscv_pkg::*;
#(
    parameter int W = XLEN
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [W-1:0]      rf_val,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [W-1:0]      wb_data,
    output logic [W-1:0]      val
);

    // NOTE: val gets a default on every path first, so no latch is inferred.
    always_comb begin
        val = rf_val;
        if (addr == '0) begin
            val = '0;
        end else if (wb_regWrite && reg_hit(wb_addr, addr)) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with x0 zeroing, WB bypass, load-use bubble
// insertion, flush, and WB snooping of held operands.
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int n        = riscv_pkg::XLEN,
    parameter int CTRL_W   = riscv_pkg::CTRL_W,
    parameter int LOAD_BIT = riscv_pkg::LOAD_BIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [n-1:0]      id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [n-1:0]      rf_rs1,
    input  logic [n-1:0]      rf_rs2,
    input  logic              wb_regWrite,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [n-1:0]      wb_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output logic [31:0]       ex_pc,
    output logic [REG_AW-1:0] ex_rs1_addr,
    output logic [REG_AW-1:0] ex_rs2_addr,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic [n-1:0]      ex_rs1_val,
    output logic [n-1:0]      ex_rs2_val,
    output logic [n-1:0]      ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [31:0]       stall_cnt
);

    logic       adv;
    logic       hazard;
    logic [n-1:0] rs1_sel;
    logic [n-1:0] rs2_sel;
    stage_act_e act;

    operand_bypass #(.W(n)) u_bypass_rs1 (
        .addr        (id_rs1_addr),
        .rf_val      (rf_rs1),
        .wb_regWrite (wb_regWrite),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .val         (rs1_sel)
    );

    operand_bypass #(.W(n)) u_bypass_rs2 (
        .addr        (id_rs2_addr),
        .rf_val      (rf_rs2),
        .wb_regWrite (wb_regWrite),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .val         (rs2_sel)
    );

    assign adv = !ex_valid || ex_ready;

    // Conservative: rs2 is compared even for instructions that do not read it.
    assign hazard = id_valid && ex_valid && ex_ctrl[LOAD_BIT]
                  && (reg_hit(ex_rd_addr, id_rs1_addr) || reg_hit(ex_rd_addr, id_rs2_addr));

    assign id_ready = flush || (adv && !hazard);

    always_comb begin
        act = ACT_CAPTURE;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (!adv) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_BUBBLE;
        end
    end

    // NOTE: all stage state uses non-blocking assignments so every field
    // updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_addr <= '0;
            ex_rs2_addr <= '0;
            ex_rd_addr  <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_ctrl     <= '0;
            stall_cnt   <= '0;
        end else begin
            unique case (act)
                ACT_FLUSH: begin
                    ex_valid <= 1'b0;
                end
                ACT_HOLD: begin
                    // Held operands track WB so EX never sees a stale value.
                    if (ex_valid && wb_regWrite && reg_hit(wb_addr, ex_rs1_addr)) begin
                        ex_rs1_val <= wb_data;
                    end
                    if (ex_valid && wb_regWrite && reg_hit(wb_addr, ex_rs2_addr)) begin
                        ex_rs2_val <= wb_data;
                    end
                end
                ACT_BUBBLE: begin
                    ex_valid  <= 1'b0;
                    stall_cnt <= stall_cnt + 32'd1;
                end
                ACT_CAPTURE: begin
                    ex_valid    <= id_valid;
                    ex_pc       <= id_pc;
                    ex_rs1_addr <= id_rs1_addr;
                    ex_rs2_addr <= id_rs2_addr;
                    ex_rd_addr  <= id_rd_addr;
                    ex_rs1_val  <= rs1_sel;
                    ex_rs2_val  <= rs2_sel;
                    ex_imm      <= id_imm;
                    ex_ctrl     <= id_ctrl;
                end
                default: begin
                    ex_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: issued instructions push their expected
// EX-register contents; a negedge monitor pops and compares on each EX handshake.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic [31:0] rf_rs1, rf_rs2;
    logic        wb_regWrite;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        flush;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [4:0]  ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
    logic [31:0] ex_rs1_val, ex_rs2_val, ex_imm;
    logic [15:0] ex_ctrl;
    logic [31:0] stall_cnt;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic [15:0] ctrl;
        logic [31:0] rf1, rf2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } id_vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] v1, v2, imm;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    id_ex_stage dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rd_addr  (id_rd_addr),
        .id_imm      (id_imm),
        .id_ctrl     (id_ctrl),
        .rf_rs1      (rf_rs1),
        .rf_rs2      (rf_rs2),
        .wb_regWrite (wb_regWrite),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_rs1_addr (ex_rs1_addr),
        .ex_rs2_addr (ex_rs2_addr),
        .ex_rd_addr  (ex_rd_addr),
        .ex_rs1_val  (ex_rs1_val),
        .ex_rs2_val  (ex_rs2_val),
        .ex_imm      (ex_imm),
        .ex_ctrl     (ex_ctrl),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid    = 1'b0;
        wb_regWrite = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    // Present an ID instruction; check id_ready; push the expected EX contents if accepted.
    task automatic issue(input id_vec_t v, input logic [31:0] e1, input logic [31:0] e2,
                         input logic exp_ready, input logic do_push, input string tag);
        exp_t e;
        id_valid    = 1'b1;
        id_pc       = v.pc;
        id_rs1_addr = v.rs1;
        id_rs2_addr = v.rs2;
        id_rd_addr  = v.rd;
        id_imm      = v.imm;
        id_ctrl     = v.ctrl;
        rf_rs1      = v.rf1;
        rf_rs2      = v.rf2;
        wb_regWrite = v.we;
        wb_addr     = v.wa;
        wb_data     = v.wd;
        #1;
        check({tag, ".id_ready"}, 64'(id_ready), 64'(exp_ready));
        if (exp_ready && do_push) begin
            e.pc = v.pc; e.rs1 = v.rs1; e.rs2 = v.rs2; e.rd = v.rd;
            e.v1 = e1;   e.v2 = e2;     e.imm = v.imm; e.ctrl = v.ctrl;
            sb_q.push_back(e);
        end
        step();
    endtask

    // Monitor: compare on every EX handshake, independent of the stimulus thread.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && ex_valid && ex_ready) begin
            if (sb_q.size() == 0) begin
                check("sb.unexpected_ex_valid", 64'(ex_pc), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb_q.pop_front();
                check("sb.pc",       64'(ex_pc),       64'(e.pc));
                check("sb.rs1_addr", 64'(ex_rs1_addr), 64'(e.rs1));
                check("sb.rs2_addr", 64'(ex_rs2_addr), 64'(e.rs2));
                check("sb.rd_addr",  64'(ex_rd_addr),  64'(e.rd));
                check("sb.rs1_val",  64'(ex_rs1_val),  64'(e.v1));
                check("sb.rs2_val",  64'(ex_rs2_val),  64'(e.v2));
                check("sb.imm",      64'(ex_imm),      64'(e.imm));
                check("sb.ctrl",     64'(ex_ctrl),     64'(e.ctrl));
            end
        end
    end

    initial begin
        id_vec_t v;
        int      waited;

        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
        id_imm = '0; id_ctrl = '0; rf_rs1 = '0; rf_rs2 = '0;
        idle();
        step(); step();
        rst = 1'b0;

        // Reset with a valid instruction previously held in EX
        ex_ready = 1'b0;
        v = '{pc:32'h40, rs1:5'd1, rs2:5'd2, rd:5'd3, imm:32'h4, ctrl:16'h0002,
              rf1:32'h777, rf2:32'h888, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h777, 32'h888, 1'b1, 1'b0, "pre_rst");
        check("pre_rst.ex_valid", 64'(ex_valid), 64'd1);
        check("pre_rst.rs1_val",  64'(ex_rs1_val), 64'h777);
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rst.ex_valid",  64'(ex_valid),   64'd0);
        check("rst.rs1_val",   64'(ex_rs1_val), 64'd0);
        check("rst.pc",        64'(ex_pc),      64'd0);
        check("rst.stall_cnt", 64'(stall_cnt),  64'd0);
        check("rst.id_ready",  64'(id_ready),   64'd1);
        ex_ready = 1'b1;

        // Same-cycle WB bypass on rs1
        v = '{pc:32'h100, rs1:5'd3, rs2:5'd4, rd:5'd6, imm:32'h10, ctrl:16'h0002,
              rf1:32'h5, rf2:32'h44, we:1'b1, wa:5'd3, wd:32'hDEAD};
        issue(v, 32'hDEAD, 32'h44, 1'b1, 1'b1, "wb_bypass");
        check("wb_bypass.ex_valid", 64'(ex_valid),   64'd1);
        check("wb_bypass.rs1_val",  64'(ex_rs1_val), 64'hDEAD);

        // x0 read is zero and a WB write to x0 is never bypassed
        v = '{pc:32'h104, rs1:5'd2, rs2:5'd0, rd:5'd7, imm:32'hFFFF_FFF0, ctrl:16'h0004,
              rf1:32'h22, rf2:32'h1234, we:1'b1, wa:5'd0, wd:32'hFF};
        issue(v, 32'h22, 32'h0, 1'b1, 1'b1, "x0_read");
        check("x0_read.rs2_val", 64'(ex_rs2_val), 64'd0);

        // WB address matches but write enable is low -> regFile value
        v = '{pc:32'h108, rs1:5'd0, rs2:5'd9, rd:5'd1, imm:32'h8, ctrl:16'h0008,
              rf1:32'h99, rf2:32'h9090, we:1'b0, wa:5'd9, wd:32'hBAD};
        issue(v, 32'h0, 32'h9090, 1'b1, 1'b1, "wb_off");

        // Load-use: load to x5, then a consumer of x5 on rs2
        v = '{pc:32'h10C, rs1:5'd1, rs2:5'd2, rd:5'd5, imm:32'h0, ctrl:16'h0001,
              rf1:32'h11, rf2:32'h12, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h11, 32'h12, 1'b1, 1'b1, "load");
        v = '{pc:32'h110, rs1:5'd8, rs2:5'd5, rd:5'd9, imm:32'h3, ctrl:16'h0002,
              rf1:32'h80, rf2:32'h50, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h80, 32'h50, 1'b0, 1'b0, "load_use_stall");
        check("load_use.ex_valid",  64'(ex_valid),  64'd0);
        check("load_use.stall_cnt", 64'(stall_cnt), 64'd1);
        issue(v, 32'h80, 32'h50, 1'b1, 1'b1, "load_use_issue");
        check("load_use.rs2_addr", 64'(ex_rs2_addr), 64'd5);

        // Hold for 3 cycles with a WB snoop of x7 in cycle 2 and an x0 write in cycle 3
        v = '{pc:32'h114, rs1:5'd7, rs2:5'd0, rd:5'd10, imm:32'h77, ctrl:16'h0004,
              rf1:32'h70, rf2:32'h90, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h55, 32'h0, 1'b1, 1'b1, "hold_cap");
        ex_ready = 1'b0;
        v = '{pc:32'h118, rs1:5'd11, rs2:5'd12, rd:5'd13, imm:32'h1, ctrl:16'h0002,
              rf1:32'hB0, rf2:32'hC0, we:1'b0, wa:5'd0, wd:32'h0};
        id_valid = 1'b1; id_pc = v.pc; id_rs1_addr = v.rs1; id_rs2_addr = v.rs2;
        id_rd_addr = v.rd; id_imm = v.imm; id_ctrl = v.ctrl; rf_rs1 = v.rf1; rf_rs2 = v.rf2;
        for (int c = 1; c <= 3; c++) begin
            wb_regWrite = (c != 1);
            wb_addr     = (c == 2) ? 5'd7 : 5'd0;
            wb_data     = (c == 2) ? 32'h55 : 32'hFF;
            #1;
            check($sformatf("hold%0d.id_ready", c), 64'(id_ready), 64'd0);
            step();
        end
        check("hold.rs1_val", 64'(ex_rs1_val), 64'h55);
        check("hold.rs2_val", 64'(ex_rs2_val), 64'd0);
        check("hold.pc",      64'(ex_pc),      64'h114);
        check("hold.imm",     64'(ex_imm),     64'h77);
        check("hold.ex_valid", 64'(ex_valid),  64'd1);
        ex_ready = 1'b1;
        issue(v, 32'hB0, 32'hC0, 1'b1, 1'b1, "after_hold");

        // Flush while a load-use hazard is pending and EX is stalled
        v = '{pc:32'h11C, rs1:5'd1, rs2:5'd2, rd:5'd13, imm:32'h0, ctrl:16'h0001,
              rf1:32'h1, rf2:32'h2, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h1, 32'h2, 1'b1, 1'b0, "flush_load");
        ex_ready = 1'b0;
        flush    = 1'b1;
        v = '{pc:32'h120, rs1:5'd13, rs2:5'd3, rd:5'd4, imm:32'h0, ctrl:16'h0002,
              rf1:32'h3, rf2:32'h4, we:1'b0, wa:5'd0, wd:32'h0};
        issue(v, 32'h3, 32'h4, 1'b1, 1'b0, "flush");
        flush = 1'b0;
        check("flush.ex_valid",  64'(ex_valid),  64'd0);
        check("flush.stall_cnt", 64'(stall_cnt), 64'd1);
        ex_ready = 1'b1;

        v = '{pc:32'h124, rs1:5'd13, rs2:5'd14, rd:5'd15, imm:32'h24, ctrl:16'h0010,
              rf1:32'hAB, rf2:32'hCD, we:1'b1, wa:5'd14, wd:32'hEE};
        issue(v, 32'hAB, 32'hEE, 1'b1, 1'b1, "post_flush");
        idle();

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            step();
            waited++;
        end
        check("sb.drained", 64'(sb_q.size()), 64'd0);
        check("final.stall_cnt", 64'(stall_cnt), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
